score_level_ctrl: RTL

Game-phase sequencer for the snake datapath.
- Owns the game_state FSM (IDLE/PLAY/PAUSE/OVER).
- Keeps a 4-digit BCD score and a high-score register.
- Derives the difficulty level from the points scored.
- Emits the snake move_tick pulse, whose period shrinks as the level rises.
- Feeds the display and movement blocks.

---
 rtl/score_level_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/score_level_ctrl.sv
// Game-phase sequencer for the snake datapath: game FSM, BCD score/high score,
// difficulty level and the level-dependent move_tick generator.
module score_level_ctrl #(
  parameter int unsigned TICK_BASE        = 25000000,
  parameter int unsigned TICK_STEP        = 2000000,
  parameter int unsigned MAX_LEVEL        = 7,
  parameter int unsigned POINTS_PER_LEVEL = 5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_pause,
  input  logic        i_target_ate,
  input  logic        i_collision,
  output logic [2:0]  o_game_state,
  output logic [15:0] o_score_bcd,
  output logic [15:0] o_high_bcd,
  output logic [2:0]  o_level,
  output logic        o_move_tick,
  output logic        o_new_high
);

  localparam int unsigned CntW = $clog2(TICK_BASE + 1);
  localparam int unsigned PtsW = $clog2(POINTS_PER_LEVEL + 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPlay  = 3'd1,
    StPause = 3'd2,
    StOver  = 3'd3
  } state_e;

  state_e          r_state, w_state_d;
  logic            r_sync1, r_sync2, r_sync3;
  logic [15:0]     r_score, r_high;
  logic [2:0]      r_level;
  logic [PtsW-1:0] r_pts;
  logic [CntW-1:0] r_cnt;
  logic            r_tick, r_new_high, r_over_first;
  logic            w_eat, w_point, w_cnt_done, w_start_game;
  logic [31:0]     w_period, w_last;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] res;
    logic        carry;
    res   = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == 4'd9) begin
          res[i*4 +: 4] = 4'd0;
        end else begin
          res[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    return res;
  endfunction

  assign w_eat        = r_sync2 & ~r_sync3;
  assign w_point      = (r_state == StPlay) && w_eat && (r_score != 16'h9999);
  assign w_period     = TICK_BASE - 32'(r_level) * TICK_STEP;
  assign w_last       = w_period - 32'd1;
  // >= rather than == so a level-up that shrinks the period never overshoots the wrap point
  assign w_cnt_done   = 32'(r_cnt) >= w_last;
  assign w_start_game = (r_state == StIdle) && (w_state_d == StPlay);

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (i_start) w_state_d = StPlay;
      StPlay: begin
        if (i_collision)  w_state_d = StOver;
        else if (i_pause) w_state_d = StPause;
      end
      StPause: if (i_pause) w_state_d = StPlay;
      StOver:  if (i_start) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_sync3      <= 1'b0;
      r_score      <= '0;
      r_high       <= '0;
      r_level      <= '0;
      r_pts        <= '0;
      r_cnt        <= '0;
      r_tick       <= 1'b0;
      r_new_high   <= 1'b0;
      r_over_first <= 1'b0;
    end else begin
      r_sync1      <= i_target_ate;
      r_sync2      <= r_sync1;
      r_sync3      <= r_sync2;
      r_tick       <= 1'b0;
      r_over_first <= (w_state_d == StOver) && (r_state != StOver);

      if (w_start_game) begin
        r_score    <= '0;
        r_level    <= '0;
        r_pts      <= '0;
        r_cnt      <= '0;
        r_new_high <= 1'b0;
      end

      if (w_point) begin
        r_score <= bcd_inc(r_score);
        if (32'(r_pts) >= POINTS_PER_LEVEL - 1) begin
          r_pts <= '0;
          if (32'(r_level) < MAX_LEVEL) r_level <= r_level + 3'd1;
        end else begin
          r_pts <= r_pts + PtsW'(1);
        end
      end

      // Counter only advances while staying in PLAY, so a pause freezes it in place
      if ((r_state == StPlay) && (w_state_d == StPlay)) begin
        if (w_cnt_done) begin
          r_cnt  <= '0;
          r_tick <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CntW'(1);
        end
      end

      if ((r_state == StOver) && r_over_first && (r_score > r_high)) begin
        r_high     <= r_score;
        r_new_high <= 1'b1;
      end
      if ((r_state == StOver) && (w_state_d != StOver)) r_new_high <= 1'b0;
    end
  end

  assign o_game_state = r_state;
  assign o_score_bcd  = r_score;
  assign o_high_bcd   = r_high;
  assign o_level      = r_level;
  assign o_move_tick  = r_tick;
  assign o_new_high   = r_new_high;

endmodule
